// File: rtl/tt_sweep_checker_pkg.sv
// Shared definitions for the truth-table sweep checker: widths, the FSM
// state type and the mapping from vector index to truth-table bit.
package tt_pkg;

    localparam int VEC_W = 3;
    localparam int TT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } tt_state_e;

    // The truth table is written MSB-first: vector 3'b000 lands in bit 7.
    function automatic logic [VEC_W-1:0] tt_bit_pos(input logic [VEC_W-1:0] idx);
        return VEC_W'(TT_W - 1) - idx;
    endfunction

endpackage

// File: rtl/tt_sweep_checker_if.sv
// Signal bundle between the sweep checker and whoever drives/observes it.
// The slave side is the checker; the master side requests sweeps and
// supplies the response of the block under test.
interface tt_sweep_checker_if;
    import tt_pkg::*;

    logic            start;
    logic            fn_out;
    logic            in1;
    logic            in2;
    logic            in3;
    logic            busy;
    logic            done;
    logic            pass;
    logic [TT_W-1:0] captured;
    logic [TT_W-1:0] mismatch;

    modport master (
        output start, fn_out,
        input  in1, in2, in3, busy, done, pass, captured, mismatch
    );

    modport slave (
        input  start, fn_out,
        output in1, in2, in3, busy, done, pass, captured, mismatch
    );

endinterface

// File: rtl/tt_sweep_checker_settle_timer.sv
// Settle counter: cleared on load, advanced on enable, and flags the last
// settle cycle so the FSM can move to capture after exactly SETTLE cycles.
module tt_settle_timer #(
    parameter int SETTLE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic term
);

    logic [7:0] cnt;

    // Count settle cycles; load restarts the count for the next vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= 8'd0;
        end else if (en) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign term = (cnt == 8'(SETTLE - 1));

endmodule

// File: rtl/tt_sweep_checker.sv
// Truth-table sweep checker: walks the 3-bit stimulus vector 000..111,
// holds each vector for SETTLE cycles, samples the block's response in a
// one-cycle capture slot and compares the collected table with EXPECTED.
module tt_sweep_checker
    import tt_pkg::*;
#(
    parameter int              SETTLE   = 4,
    parameter logic [TT_W-1:0] EXPECTED = 8'hAE
) (
    input  logic               clk,
    input  logic               reset,
    tt_sweep_checker_if.slave  bus
);

    tt_state_e        state;
    logic [VEC_W-1:0] idx;
    logic             busy_r;
    logic             done_r;
    logic             pass_r;
    logic [TT_W-1:0]  cap_r;
    logic [TT_W-1:0]  mis_r;
    logic [TT_W-1:0]  cap_next;
    logic             tmr_load;
    logic             tmr_en;
    logic             tmr_term;

    // Timer restarts when a sweep begins and at every capture slot, and only
    // runs while a vector is settling.
    always_comb begin
        tmr_load = ((state == ST_IDLE) && bus.start) || (state == ST_CAPTURE);
        tmr_en   = (state == ST_SETTLE) && !tmr_term;
    end

    tt_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .en    (tmr_en),
        .term  (tmr_term)
    );

    // Captured table with the current response merged in at this vector's bit;
    // used both for the register update and for the final pass/mismatch.
    always_comb begin
        cap_next                  = cap_r;
        cap_next[tt_bit_pos(idx)] = bus.fn_out;
    end

    // Sweep controller; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            idx    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            pass_r <= 1'b0;
            cap_r  <= '0;
            mis_r  <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        idx    <= '0;
                        cap_r  <= '0;
                        pass_r <= 1'b0;
                        mis_r  <= '0;
                        busy_r <= 1'b1;
                        state  <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_term) begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    cap_r <= cap_next;
                    if (idx == VEC_W'(TT_W - 1)) begin
                        // Last vector: results become visible with the done pulse.
                        done_r <= 1'b1;
                        pass_r <= (cap_next == EXPECTED);
                        mis_r  <= cap_next ^ EXPECTED;
                        state  <= ST_DONE;
                    end else begin
                        idx   <= idx + VEC_W'(1);
                        state <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    // Vector returns to 000 and results stay held while idle.
                    idx    <= '0;
                    busy_r <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in1      = idx[2];
    assign bus.in2      = idx[1];
    assign bus.in3      = idx[0];
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.pass     = pass_r;
    assign bus.captured = cap_r;
    assign bus.mismatch = mis_r;

endmodule
